// File: rtl/alu_share_if.sv
// ---------------------------------------------------------------------------
// alu_share_if
// Bundles the signals around the shared ALU arbiter:
//   - two requester channels (valid/ready + op, operand A, operand B)
//   - the operand/op bus driven into the combinational ALU and its result
//   - the one-entry response channel (valid/ready + id + data)
// Modports:
//   slave  : the arbiter side (receives requests, drives ALU bus, owns response)
//   master : the environment side (requesters, ALU result, response consumer)
// ---------------------------------------------------------------------------
interface alu_share_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
);
  // Requester 0 (execute stage)
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  // Requester 1 (address/branch-target unit)
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  // Shared ALU bus
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational DATA_W-bit ALU between the execute stage
// (requester 0) and the address/branch-target unit (requester 1). Each cycle
// the response slot is free, one valid requester is granted, its op/operands
// are driven onto the ALU bus in the same cycle, and the ALU result is
// captured on the clock edge into a one-entry response register tagged with
// the requester id (result visible the cycle after the grant).
//
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_share_if.slave
//            req0_* / req1_* : requester valid/ready/op/a/b
//            alu_op/a/b      : operands to the ALU (zero when nothing granted)
//            alu_result      : combinational ALU result
//            rsp_*           : response valid/ready/id/data
//
// Parameters:
//   DATA_W      : operand/result width
//   OP_W        : ALU op-code width (op 0 = nop)
//   ROUND_ROBIN : 1 = alternate between contending requesters,
//                 0 = fixed priority with requester 0 highest
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_W      = 16,
  parameter int OP_W        = 4,
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus
);

  // State
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rr_ptr;     // requester preferred on the next contention

  // Combinational arbitration
  logic              w_slot_free;
  logic              w_any_valid;
  logic              w_winner;
  logic              w_grant;

  // The slot can accept a new result if it is empty or being drained now.
  assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
  assign w_any_valid = bus.req0_valid || bus.req1_valid;

  always_comb begin
    w_winner = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_winner = (ROUND_ROBIN != 0) ? r_rr_ptr : 1'b0;
    end else if (bus.req1_valid) begin
      w_winner = 1'b1;
    end
  end

  // rst_n is folded in so nothing is granted (and the ALU sees a nop) while
  // reset is held, even though the empty response slot reads as free.
  assign w_grant = rst_n && w_slot_free && w_any_valid;

  assign bus.req0_ready = w_grant && (w_winner == 1'b0);
  assign bus.req1_ready = w_grant && (w_winner == 1'b1);

  // ALU operand bus: winner's payload on a grant, otherwise all-zero nop.
  always_comb begin
    bus.alu_op = '0;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    if (w_grant) begin
      if (w_winner) begin
        bus.alu_op = bus.req1_op;
        bus.alu_a  = bus.req1_a;
        bus.alu_b  = bus.req1_b;
      end else begin
        bus.alu_op = bus.req0_op;
        bus.alu_a  = bus.req0_a;
        bus.alu_b  = bus.req0_b;
      end
    end
  end

  // Response register and round-robin pointer. A grant in the same cycle as
  // a drain simply replaces the entry, keeping rsp_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rr_ptr    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_winner;
        r_rsp_data  <= bus.alu_result;
        r_rr_ptr    <= ~w_winner;
      end else if (bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int DW = 16;
  localparam int OW = 4;

  logic clk;
  logic rst_n;

  alu_share_if #(.DATA_W(DW), .OP_W(OW)) bus_rr ();
  alu_share_if #(.DATA_W(DW), .OP_W(OW)) bus_fp ();

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW), .ROUND_ROBIN(1)) u_dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW), .ROUND_ROBIN(0)) u_dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU
  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      4'd1:    alu_f = a + b;
      4'd2:    alu_f = a - b;
      4'd3:    alu_f = a & b;
      4'd4:    alu_f = a | b;
      4'd5:    alu_f = a ^ b;
      default: alu_f = '0;
    endcase
  endfunction

  always_comb bus_rr.alu_result = alu_f(bus_rr.alu_op, bus_rr.alu_a, bus_rr.alu_b);
  always_comb bus_fp.alu_result = alu_f(bus_fp.alu_op, bus_fp.alu_a, bus_fp.alu_b);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          v0;
    logic [OW-1:0] op0;
    logic [DW-1:0] a0;
    logic [DW-1:0] b0;
    logic          v1;
    logic [OW-1:0] op1;
    logic [DW-1:0] a1;
    logic [DW-1:0] b1;
    logic          rdy;
    logic          e_r0;
    logic          e_r1;
    logic [OW-1:0] e_op;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    logic          e_rv;
    logic          e_id;
    logic [DW-1:0] e_data;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic drive_rr(input vec_t v);
    bus_rr.req0_valid = v.v0;
    bus_rr.req0_op    = v.op0;
    bus_rr.req0_a     = v.a0;
    bus_rr.req0_b     = v.b0;
    bus_rr.req1_valid = v.v1;
    bus_rr.req1_op    = v.op1;
    bus_rr.req1_a     = v.a1;
    bus_rr.req1_b     = v.b1;
    bus_rr.rsp_ready  = v.rdy;
  endtask

  task automatic fp_drive(input logic v0, input logic v1);
    bus_fp.req0_valid = v0;
    bus_fp.req0_op    = 4'd1;
    bus_fp.req0_a     = 16'h0005;
    bus_fp.req0_b     = 16'h0006;
    bus_fp.req1_valid = v1;
    bus_fp.req1_op    = 4'd5;
    bus_fp.req1_a     = 16'hFF00;
    bus_fp.req1_b     = 16'h0F0F;
    bus_fp.rsp_ready  = 1'b1;
  endtask

  initial begin
    // idle/v0/op0/a0/b0/v1/op1/a1/b1/rdy | r0/r1/op/a/b | rv/id/data
    tbl[0]  = '{1'b1, 4'h1, 16'h0003, 16'h0004, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1,
                1'b1, 1'b0, 4'h1, 16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0007};
    tbl[1]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h2, 16'h0010, 16'h0003, 1'b1,
                1'b0, 1'b1, 4'h2, 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D};
    // Contention, rr_ptr = 0 here: 0,1,0,1
    tbl[2]  = '{1'b1, 4'h1, 16'h0001, 16'h0001, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1,
                1'b1, 1'b0, 4'h1, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002};
    tbl[3]  = '{1'b1, 4'h1, 16'h0001, 16'h0001, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1,
                1'b0, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1, 1'b1, 16'h0030};
    tbl[4]  = '{1'b1, 4'h1, 16'h0001, 16'h0001, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1,
                1'b1, 1'b0, 4'h1, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002};
    tbl[5]  = '{1'b1, 4'h1, 16'h0001, 16'h0001, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1,
                1'b0, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1, 1'b1, 16'h0030};
    // Backpressure for 3 cycles: no grant, response held
    tbl[6]  = '{1'b1, 4'h1, 16'h0001, 16'h0001, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b0,
                1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0030};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    // Drain resumes: requester 0 (not the last winner) granted same cycle
    tbl[9]  = '{1'b1, 4'h1, 16'h0001, 16'h0001, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1,
                1'b1, 1'b0, 4'h1, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002};
    // Idle with drain: valid drops, data/id hold
    tbl[10] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1,
                1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0002};
    tbl[11] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h3, 16'h00F0, 16'h0FF0, 1'b1,
                1'b0, 1'b1, 4'h3, 16'h00F0, 16'h0FF0, 1'b1, 1'b1, 16'h00F0};
    // Op 0 is still granted; ALU returns 0
    tbl[12] = '{1'b1, 4'h0, 16'h1234, 16'h0005, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1,
                1'b1, 1'b0, 4'h0, 16'h1234, 16'h0005, 1'b1, 1'b0, 16'h0000};
    // Wrap-around add
    tbl[13] = '{1'b1, 4'h1, 16'hFFFF, 16'h0001, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1,
                1'b1, 1'b0, 4'h1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000};
    // Full slot, not drained: stall
    tbl[14] = '{1'b1, 4'h2, 16'h0009, 16'h0001, 1'b1, 4'h1, 16'h0002, 16'h0002, 1'b0,
                1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[15] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1,
                1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    // Empty slot is free even with rsp_ready=0
    tbl[16] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h4, 16'h0F00, 16'h00F0, 1'b0,
                1'b0, 1'b1, 4'h4, 16'h0F00, 16'h00F0, 1'b1, 1'b1, 16'h0FF0};
    tbl[17] = '{1'b1, 4'h1, 16'h0007, 16'h0007, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0,
                1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0FF0};

    // ---------------- Reset held with both requesters valid
    rst_n = 1'b0;
    fp_drive(1'b0, 1'b0);
    drive_rr('{1'b1, 4'h1, 16'h0001, 16'h0002, 1'b1, 4'h1, 16'h0100, 16'h0200, 1'b1,
               1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus_rr.rsp_valid), 32'd0);
    chk("reset_rsp_data",  32'(bus_rr.rsp_data),  32'h0);
    chk("reset_ready0",    32'(bus_rr.req0_ready), 32'd0);
    chk("reset_ready1",    32'(bus_rr.req1_ready), 32'd0);
    chk("reset_alu_op",    32'(bus_rr.alu_op),     32'd0);

    // Release: first grant to requester 0
    rst_n = 1'b1;
    #2;
    chk("rel_ready0", 32'(bus_rr.req0_ready), 32'd1);
    chk("rel_ready1", 32'(bus_rr.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_rsp_id",   32'(bus_rr.rsp_id),   32'd0);
    chk("rel_rsp_data", 32'(bus_rr.rsp_data), 32'h0003);

    // ---------------- Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive_rr(tbl[i]);
      #3;
      chk($sformatf("v%0d_ready0", i), 32'(bus_rr.req0_ready), 32'(tbl[i].e_r0));
      chk($sformatf("v%0d_ready1", i), 32'(bus_rr.req1_ready), 32'(tbl[i].e_r1));
      chk($sformatf("v%0d_alu_op", i), 32'(bus_rr.alu_op),     32'(tbl[i].e_op));
      chk($sformatf("v%0d_alu_a", i),  32'(bus_rr.alu_a),      32'(tbl[i].e_a));
      chk($sformatf("v%0d_alu_b", i),  32'(bus_rr.alu_b),      32'(tbl[i].e_b));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), 32'(bus_rr.rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d_rsp_id", i),    32'(bus_rr.rsp_id),    32'(tbl[i].e_id));
      chk($sformatf("v%0d_rsp_data", i),  32'(bus_rr.rsp_data),  32'(tbl[i].e_data));
    end

    // ---------------- Async reset mid-stream (rsp_valid=1 here)
    #1;
    rst_n = 1'b0;
    #2;
    chk("areset_rsp_valid", 32'(bus_rr.rsp_valid), 32'd0);
    chk("areset_rsp_data",  32'(bus_rr.rsp_data),  32'h0);
    chk("areset_ready0",    32'(bus_rr.req0_ready), 32'd0);
    drive_rr('{1'b1, 4'h1, 16'hFFFF, 16'h0001, 1'b1, 4'h1, 16'h0010, 16'h0020, 1'b1,
               1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;
    #1;
    // rr_ptr cleared: requester 0 preferred again
    chk("post_areset_ready0", 32'(bus_rr.req0_ready), 32'd1);
    chk("post_areset_ready1", 32'(bus_rr.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_areset_rsp_valid", 32'(bus_rr.rsp_valid), 32'd1);
    chk("post_areset_rsp_data",  32'(bus_rr.rsp_data),  32'h0000);
    drive_rr('{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1,
               1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});

    // ---------------- Fixed priority instance
    fp_drive(1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #3;
      chk($sformatf("fp%0d_ready0", c), 32'(bus_fp.req0_ready), 32'd1);
      chk($sformatf("fp%0d_ready1", c), 32'(bus_fp.req1_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("fp%0d_rsp_id", c),   32'(bus_fp.rsp_id),   32'd0);
      chk($sformatf("fp%0d_rsp_data", c), 32'(bus_fp.rsp_data), 32'h000B);
    end
    fp_drive(1'b0, 1'b1);
    #3;
    chk("fp_drop_ready0", 32'(bus_fp.req0_ready), 32'd0);
    chk("fp_drop_ready1", 32'(bus_fp.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("fp_drop_rsp_id",   32'(bus_fp.rsp_id),   32'd1);
    chk("fp_drop_rsp_data", 32'(bus_fp.rsp_data), 32'hF00F);
    fp_drive(1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
